fxu_pipe: RTL and testbench
===========================

# fxu_pipe

Parametrised fixed-point execution unit for the out-of-order core. It sits between the reservation stations and the ROB writeback bus. Single-cycle ALU ops complete in one cycle; an iterative shift-add multiplier handles `MUL` over several cycles. Results leave in issue order through an output FIFO with a valid/ready handshake, so writeback backpressure never drops a result.

## Interface
- `DATA_W`, 16: operand and result width; ≥ `IMM_W`, ≥ 4.
- `IMM_W`, 8: immediate width.
- `TAG_W`, 4: ROB index width.
- `OUT_DEPTH`, 2: output FIFO entries; power of two, ≥ 2.

- `clk` in 1: clock; one clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: issue request.
- `in_ready` out 1: unit accepts the issue this cycle.
- `opcode` in 4: operation code, values from `fxu_pkg`.
- `in_tag` in `TAG_W`: ROB index of the issued op.
- `va`, `vb` in `DATA_W`: decoded operands.
- `imm` in `IMM_W`: decoded immediate.
- `out_valid` out 1: FIFO head holds a result.
- `out_ready` in 1: writeback consumes the head.
- `out_tag` out `TAG_W`: ROB index of the head result.
- `out_value` out `DATA_W`: head result.

## Operation
- Accept when `in_valid && in_ready`. `in_ready = (state==IDLE) && (count < OUT_DEPTH)`. It has no combinational dependence on `out_ready` or `in_valid`.
- Opcodes:
  - 0000 ADD: `va+vb`.
  - 0001 SUB: `va-vb`.
  - 0010 AND.
  - 0011 OR.
  - 0111 XOR.
  - 0100 MOV: `va`.
  - 0101 MOVL: `{va[DATA_W-1:IMM_W], imm}`.
  - 0110 MOVH: `{imm, va[DATA_W-IMM_W-1:0]}`.
  - 1000 SHL: `va << vb[clog2(DATA_W)-1:0]`.
  - 1001 SHR: logical right shift, same shift-amount field.
  - 1010 MUL.
  - All other codes: result 0, still pushed with its tag.
- Arithmetic is modulo 2^`DATA_W`. Carries and overflow are discarded. MUL returns the low `DATA_W` bits of the product.
- FSM:
  - IDLE: accepting ALU ops, or a MUL that moves to MUL_RUN.
  - MUL_RUN: `DATA_W` iterations driven by a counter `0..DATA_W-1`. Each iteration adds (multiplicand << i) to the accumulator when multiplier bit i is set. After the last iteration it moves to MUL_DONE.
  - MUL_DONE: pushes `{tag, acc}` and returns to IDLE.
- Operands and tag are latched at accept. Input buses are don't-care afterwards.
- Space reservation: a MUL is accepted only with a free FIFO slot. No push occurs while the MUL is in flight, so the MUL_DONE push never sees a full FIFO.
- Results exit strictly in accept order.

## Timing
- ALU op accepted at edge N is pushed at edge N. `out_valid` can be high from cycle N+1, giving a latency of 1.
- MUL accepted at edge N:
  - Iterations run on edges N+1..N+`DATA_W`.
  - Push occurs at edge N+`DATA_W`+1.
  - `in_ready` is low for cycles N+1..N+`DATA_W`+1.
  - Latency is `DATA_W`+1.
- Back-to-back ALU issues are sustained at 1 per cycle while `out_ready` stays high.
- Push and pop on the same edge: count unchanged. Pop on an empty FIFO is impossible because `out_valid` gates it.
- Full FIFO: `in_ready` is 0 until a pop edge. Ready returns on the cycle after that pop.
- `out_tag`/`out_value` are stable while `out_valid && !out_ready`.
- Reset state: `state=IDLE`, `count=0`, counter 0, accumulator 0.
  - Outputs after reset: `out_valid=0`, `out_tag=0`, `out_value=0`, `in_ready=1`.
- Reset mid-MUL or with FIFO occupied: all in-flight and queued results are discarded with no output pulse.

## Structure
- `fxu_pkg` holds the opcode constants (`OP_ADD` … `OP_MUL`), `OP_W=4`, and the FSM state enum.
- Sub-module `fxu_out_fifo`, parametrised by width (`TAG_W+DATA_W`) and `OUT_DEPTH`, provides:
  - push/pop, `count`, and a registered head.
  - asynchronous active-low reset.
- Top level holds the ALU mux, the MUL datapath/FSM, and the `in_ready` logic.

## Test plan
- ADD: `va=16'h1234`, `vb=16'h0001`, tag 3 → one cycle later `out_valid=1`, `out_value=16'h1235`, `out_tag=3`.
- SUB wrap and MOVL/MOVH:
  - SUB `0x0000-0x0001` → `0xFFFF`.
  - `va=16'hABCD`, `imm=8'h5A` → MOVL `16'hAB5A`, MOVH `16'h5ACD`.
- MUL: `16'h0012*16'h0034`, tag 7.
  - `in_ready` low for 17 cycles.
  - Result `16'h03A8` arrives 17 cycles after accept.
  - `16'hFFFF*16'hFFFF` → `16'h0001`.
- Backpressure: `out_ready=0`, three ADDs with tags 1, 2, 3.
  - Two are accepted, then `in_ready=0`.
  - Raising `out_ready` drains tags 1, 2, 3 in order with no loss or duplication.
- Mixed order: MUL (tag 4) then ADD (tag 5).
  - ADD is stalled until MUL_DONE.
  - Outputs are tag 4 then tag 5.
- Reset: assert `rst_n=0` mid-MUL with one queued result.
  - All outputs return to 0 immediately.
  - No result emerges after release.
  - `in_ready=1`.

Source files
------------

// File: rtl/fxu_pkg.sv
// fxu_pkg: shared definitions for the fixed-point execution unit.
//   - OP_W and the opcode constants decoded by fxu_pipe
//   - fxu_state_e: sequencing states (single-cycle issue vs. iterative MUL)
package fxu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
  localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
  localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
  localparam logic [OP_W-1:0] OP_MOV  = 4'b0100;
  localparam logic [OP_W-1:0] OP_MOVL = 4'b0101;
  localparam logic [OP_W-1:0] OP_MOVH = 4'b0110;
  localparam logic [OP_W-1:0] OP_XOR  = 4'b0111;
  localparam logic [OP_W-1:0] OP_SHL  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SHR  = 4'b1001;
  localparam logic [OP_W-1:0] OP_MUL  = 4'b1010;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } fxu_state_e;

endpackage

// File: rtl/fxu_out_fifo.sv
// fxu_out_fifo: small in-order result FIFO with a flop-based head.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears contents)
//   push, push_data     write one entry (caller guarantees a free slot)
//   pop                 consume the head; ignored when empty
//   count               current occupancy, 0..DEPTH
//   head_valid, head    head entry; head reads 0 after reset
module fxu_out_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output logic [W-1:0]             head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          pop_eff;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    pop_eff  = pop && (count_q != '0);

    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop_eff})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fxu_pipe.sv
// fxu_pipe: fixed-point execution unit between reservation stations and ROB writeback.
// Single-cycle ALU ops are pushed into the output FIFO on the accept edge; MUL runs
// an iterative shift-add over DATA_W cycles and pushes from MUL_DONE.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          issue handshake
//   opcode, in_tag, va, vb, imm  decoded issue payload
//   out_valid/out_ready        writeback handshake
//   out_tag, out_value         head result
module fxu_pipe
  import fxu_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int IMM_W     = 8,
  parameter int TAG_W     = 4,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   opcode,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [DATA_W-1:0] va,
  input  logic [DATA_W-1:0] vb,
  input  logic [IMM_W-1:0]  imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [DATA_W-1:0] out_value
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int FW   = TAG_W + DATA_W;
  localparam int CW   = $clog2(OUT_DEPTH) + 1;

  fxu_state_e        state_q, state_d;
  logic [SH_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0] mplier_q, mplier_d;
  logic [TAG_W-1:0]  tag_q, tag_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_push;
  logic [FW-1:0]     fifo_push_data;
  logic [FW-1:0]     fifo_head;
  logic              accept;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] hi_mask;
  logic [DATA_W-1:0] lo_mask;

  // A MUL is only accepted with a free slot, and nothing else pushes while it
  // runs, so the MUL_DONE push always finds room.
  assign in_ready = (state_q == IDLE) && (fifo_count < CW'(OUT_DEPTH));
  assign accept   = in_valid && in_ready;

  // Masks keep MOVL/MOVH legal even when IMM_W == DATA_W.
  assign imm_ext = DATA_W'(imm);
  assign hi_mask = {DATA_W{1'b1}} << IMM_W;
  assign lo_mask = {DATA_W{1'b1}} >> IMM_W;

  always_comb begin
    alu_result = '0;
    case (opcode)
      OP_ADD:  alu_result = va + vb;
      OP_SUB:  alu_result = va - vb;
      OP_AND:  alu_result = va & vb;
      OP_OR:   alu_result = va | vb;
      OP_XOR:  alu_result = va ^ vb;
      OP_MOV:  alu_result = va;
      OP_MOVL: alu_result = (va & hi_mask) | imm_ext;
      OP_MOVH: alu_result = (va & lo_mask) | (imm_ext << (DATA_W - IMM_W));
      OP_SHL:  alu_result = va << vb[SH_W-1:0];
      OP_SHR:  alu_result = va >> vb[SH_W-1:0];
      default: alu_result = '0;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    acc_d          = acc_q;
    mcand_d        = mcand_q;
    mplier_d       = mplier_q;
    tag_d          = tag_q;
    fifo_push      = 1'b0;
    fifo_push_data = {in_tag, alu_result};

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (opcode == OP_MUL) begin
            mcand_d  = va;
            mplier_d = vb;
            tag_d    = in_tag;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = MUL_RUN;
          end else begin
            fifo_push = 1'b1;
          end
        end
      end
      MUL_RUN: begin
        if (mplier_q[cnt_q]) begin
          acc_d = acc_q + (mcand_q << cnt_q);
        end
        if (cnt_q == SH_W'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = MUL_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      MUL_DONE: begin
        fifo_push      = 1'b1;
        fifo_push_data = {tag_q, acc_q};
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      tag_q    <= tag_d;
    end
  end

  fxu_out_fifo #(
    .W     (FW),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (fifo_push_data),
    .pop        (out_ready),
    .count      (fifo_count),
    .head_valid (out_valid),
    .head       (fifo_head)
  );

  assign out_tag   = fifo_head[FW-1:DATA_W];
  assign out_value = fifo_head[DATA_W-1:0];

endmodule

// File: tb/tb_fxu_pipe.sv
// tb_fxu_pipe: directed + randomized stimulus for fxu_pipe, checked against a
// transaction-level reference (expected result queue, MUL busy window).
module tb_fxu_pipe;
  import fxu_pkg::*;

  localparam int DATA_W    = 16;
  localparam int IMM_W     = 8;
  localparam int TAG_W     = 4;
  localparam int OUT_DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   opcode;
  logic [TAG_W-1:0]  in_tag;
  logic [DATA_W-1:0] va, vb;
  logic [IMM_W-1:0]  imm;
  logic              out_valid;
  logic              out_ready;
  logic [TAG_W-1:0]  out_tag;
  logic [DATA_W-1:0] out_value;

  fxu_pipe #(
    .DATA_W(DATA_W), .IMM_W(IMM_W), .TAG_W(TAG_W), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .in_tag(in_tag), .va(va), .vb(vb), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_tag(out_tag), .out_value(out_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] value;
  } res_t;

  res_t q[$];
  res_t pend;
  int   mul_left;
  int   n_checks;
  int   n_pass;
  bit   last_accept;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Result of an op computed directly from the opcode table, modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] ref_op(input logic [3:0] op, input int unsigned a,
                                               input int unsigned b, input int unsigned im);
    longint unsigned m;
    longint unsigned r;
    int unsigned     sh;
    m  = (longint'(1) << DATA_W) - 1;
    sh = b % DATA_W;
    case (op)
      4'd0:  r = a + b;
      4'd1:  r = a + (m + 1) - b;
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd7:  r = a ^ b;
      4'd4:  r = a;
      4'd5:  r = ((a >> IMM_W) << IMM_W) | im;
      4'd6:  r = (longint'(im) << (DATA_W - IMM_W)) | (a % (1 << (DATA_W - IMM_W)));
      4'd8:  r = longint'(a) << sh;
      4'd9:  r = a >> sh;
      4'd10: r = longint'(a) * longint'(b);
      default: r = 0;
    endcase
    return DATA_W'(r & m);
  endfunction

  // One clock: check outputs at negedge, advance the model at posedge.
  task automatic cycle();
    bit   exp_ready;
    bit   do_pop;
    res_t r;
    @(negedge clk);
    exp_ready = (mul_left == 0) && (q.size() < OUT_DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_ready));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("out_tag", 32'(out_tag), 32'(q[0].tag));
      chk("out_value", 32'(out_value), 32'(q[0].value));
    end
    do_pop      = (q.size() != 0) && out_ready;
    last_accept = in_valid && exp_ready;
    r.tag   = in_tag;
    r.value = ref_op(opcode, va, vb, imm);
    @(posedge clk);
    if (do_pop) void'(q.pop_front());
    if (mul_left > 0) begin
      mul_left--;
      if (mul_left == 0) q.push_back(pend);
    end
    if (last_accept) begin
      if (opcode == OP_MUL) begin
        pend     = r;
        mul_left = DATA_W + 1;
      end else begin
        q.push_back(r);
      end
    end
    #1;
  endtask

  task automatic set_in(input logic [3:0] op, input logic [TAG_W-1:0] t,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input logic [IMM_W-1:0] im);
    opcode = op; in_tag = t; va = a; vb = b; imm = im; in_valid = 1'b1;
  endtask

  task automatic send(input logic [3:0] op, input logic [TAG_W-1:0] t,
                      input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                      input logic [IMM_W-1:0] im);
    bit done;
    done = 0;
    set_in(op, t, a, b, im);
    for (int i = 0; i < 100 && !done; i++) begin
      cycle();
      done = last_accept;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    n_checks = 0; n_pass = 0; mul_left = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    opcode = '0; in_tag = '0; va = '0; vb = '0; imm = '0;
    #22;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_out_value", 32'(out_value), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD, latency 1
    send(OP_ADD, 4'd3, 16'h1234, 16'h0001, 8'h00);
    @(negedge clk);
    chk("add_value", 32'(out_value), 32'h1235);
    chk("add_tag", 32'(out_tag), 32'd3);
    @(posedge clk); #1; void'(q.pop_front());

    // SUB wrap, MOVL, MOVH
    send(OP_SUB, 4'd1, 16'h0000, 16'h0001, 8'h00);
    send(OP_MOVL, 4'd2, 16'hABCD, 16'h0000, 8'h5A);
    send(OP_MOVH, 4'd3, 16'hABCD, 16'h0000, 8'h5A);
    idle(3);

    // MUL: ready low for DATA_W+1 cycles, then the product
    send(OP_MUL, 4'd7, 16'h0012, 16'h0034, 8'h00);
    for (int i = 0; i < DATA_W + 1; i++) begin
      cycle();
    end
    @(negedge clk);
    chk("mul_value", 32'(out_value), 32'h03A8);
    chk("mul_tag", 32'(out_tag), 32'd7);
    @(posedge clk); #1; void'(q.pop_front());
    send(OP_MUL, 4'd8, 16'hFFFF, 16'hFFFF, 8'h00);
    idle(DATA_W + 3);

    // Backpressure: two ADDs fit, third waits until a pop
    out_ready = 1'b0;
    send(OP_ADD, 4'd1, 16'd10, 16'd1, 8'h00);
    send(OP_ADD, 4'd2, 16'd20, 16'd2, 8'h00);
    set_in(OP_ADD, 4'd3, 16'd30, 16'd3, 8'h00);
    idle(3);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    send(OP_ADD, 4'd3, 16'd30, 16'd3, 8'h00);
    idle(4);

    // Mixed order: ADD waits behind the MUL
    send(OP_MUL, 4'd4, 16'd300, 16'd7, 8'h00);
    send(OP_ADD, 4'd5, 16'd1, 16'd1, 8'h00);
    idle(4);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        set_in(4'($urandom_range(0, 15)), TAG_W'($urandom), DATA_W'($urandom),
               ($urandom_range(0, 3) == 0) ? DATA_W'(16'hFFFF) : DATA_W'($urandom),
               IMM_W'($urandom));
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(DATA_W + 4);

    // Reset mid-MUL with one queued result
    out_ready = 1'b0;
    send(OP_ADD, 4'd9, 16'd5, 16'd6, 8'h00);
    send(OP_MUL, 4'd10, 16'd3, 16'd3, 8'h00);
    idle(5);
    #2; rst_n = 1'b0; #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_tag", 32'(out_tag), 32'd0);
    chk("mid_rst_out_value", 32'(out_value), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    q.delete(); mul_left = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    idle(DATA_W + 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
